// File: rtl/cpu_boot_ctrl_if.sv
// Program-load stream between the test harness and cpu_boot_ctrl.
// A word transfers on any cycle where in_valid and in_ready are both high.
interface cpu_boot_ctrl_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer for the 16-bit CPU: streams a program into imem, pulses clear, then runs to HLT or a cycle limit.
// Optional single-step support is compiled in with `define CPU_BOOT_STEP_EN.
module cpu_boot_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             load_start,
  input  logic [8:0]       load_len,
  input  logic             run_start,
  cpu_boot_ctrl_if.slave   in_if,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             cpu_hlt,
`ifdef CPU_BOOT_STEP_EN
  input  logic             step_mode,
  input  logic             step_req,
`endif
  output logic             cpu_clr_n,
  output logic             cpu_pc_en,
  output logic             cpu_instr2mem_en,
  output logic             cpu_imem_en,
  output logic [15:0]      cpu_instr_addr,
  output logic [15:0]      cpu_instr_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [8:0]       len;
  logic [7:0]       wr_ptr;
  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] limit_q;

  logic idle_like, start_load, start_run, accept, last_word, adv, hit_limit, crst_last;
  logic step_mode_q, step_pulse;
  logic clr_n_d, pc_en_d, i2m_d, busy_d, done_d;

`ifdef CPU_BOOT_STEP_EN
  logic step_q;
  always_ff @(posedge CLK) begin
    if (CLR) begin
      step_q      <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      step_q <= step_req;
      if (state_nxt == S_CRST && state != S_CRST) step_mode_q <= step_mode;
    end
  end
  assign step_pulse = step_req & ~step_q;
`else
  assign step_mode_q = 1'b0;
  assign step_pulse  = 1'b0;
`endif

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign start_load = idle_like && load_start && (load_len != 9'd0);
  assign start_run  = idle_like && run_start && !start_load;
  assign accept     = (state == S_LOAD) && in_if.in_valid && !CLR;
  assign last_word  = (({1'b0, wr_ptr} + 9'd1) == len);
  // cpu_pc_en marks the cycles the CPU actually advances; only those count
  assign adv        = (state == S_RUN) && cpu_pc_en;
  assign hit_limit  = (limit_q != '0) && (cycles == limit_q - CNT_W'(1));
  assign crst_last  = (rst_cnt == RC_W'(RST_CYCLES - 1));

  // Write path is combinational so a word lands on the edge that accepts it
  assign in_if.in_ready = (state == S_LOAD) && !CLR;
  assign cpu_imem_en    = accept;
  assign cpu_instr_in   = in_if.in_data;
  assign cpu_instr_addr = {8'b0, wr_ptr};

  always_ff @(posedge CLK) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_load)     state_nxt = S_LOAD;
        else if (start_run) state_nxt = S_CRST;
      end
      S_LOAD: if (accept && last_word)            state_nxt = S_CRST;
      S_CRST: if (crst_last)                      state_nxt = S_RUN;
      S_RUN:  if (adv && (cpu_hlt || hit_limit))  state_nxt = S_DONE;
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered
  always_comb begin
    clr_n_d = (state_nxt == S_RUN) || (state_nxt == S_DONE);
    pc_en_d = (state_nxt == S_RUN) && (!step_mode_q || step_pulse);
    i2m_d   = (state_nxt == S_LOAD);
    busy_d  = !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
    done_d  = (state_nxt == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cpu_clr_n        <= 1'b0;
      cpu_pc_en        <= 1'b0;
      cpu_instr2mem_en <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout          <= 1'b0;
      cycles           <= '0;
      len              <= '0;
      wr_ptr           <= '0;
      rst_cnt          <= '0;
      limit_q          <= '0;
    end else begin
      cpu_clr_n        <= clr_n_d;
      cpu_pc_en        <= pc_en_d;
      cpu_instr2mem_en <= i2m_d;
      busy             <= busy_d;
      done             <= done_d;

      if (start_load) begin
        len    <= (load_len > 9'd256) ? 9'd256 : load_len;
        wr_ptr <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 8'd1;
      end

      rst_cnt <= (state == S_CRST) ? rst_cnt + RC_W'(1) : '0;
      if (state_nxt == S_CRST && state != S_CRST) limit_q <= cycle_limit;

      if (start_load || start_run) begin
        cycles  <= '0;
        timeout <= 1'b0;
      end else begin
        if (adv && cycles != '1) cycles <= cycles + CNT_W'(1);
        // HLT has priority over the limit in the same cycle
        if (state == S_RUN && state_nxt == S_DONE) timeout <= !cpu_hlt;
      end
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: load, HLT, limit, priority, backpressure and abort scenarios.
module tb_cpu_boot_ctrl;
  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        load_start = 1'b0;
  logic [8:0]  load_len = '0;
  logic        run_start = 1'b0;
  logic [15:0] cycle_limit = '0;
  logic        cpu_hlt = 1'b0;
  logic        cpu_clr_n, cpu_pc_en, cpu_instr2mem_en, cpu_imem_en;
  logic [15:0] cpu_instr_addr, cpu_instr_in;
  logic        busy, done, timeout;
  logic [15:0] cycles;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  cpu_boot_ctrl_if bus();

  cpu_boot_ctrl #(.RST_CYCLES(2), .CNT_W(16)) dut (
    .CLK(CLK), .CLR(CLR),
    .load_start(load_start), .load_len(load_len), .run_start(run_start),
    .in_if(bus),
    .cycle_limit(cycle_limit), .cpu_hlt(cpu_hlt),
    .cpu_clr_n(cpu_clr_n), .cpu_pc_en(cpu_pc_en), .cpu_instr2mem_en(cpu_instr2mem_en),
    .cpu_imem_en(cpu_imem_en), .cpu_instr_addr(cpu_instr_addr), .cpu_instr_in(cpu_instr_in),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (cpu_imem_en === 1'b1) wr_cnt++;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic pulse_load(input logic [8:0] n);
    load_len = n; load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic pulse_run;
    run_start = 1'b1; tick(); run_start = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_pc_en === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Starts at the first RUN cycle; raises HLT on RUN cycle hlt_at (0 = never)
  task automatic run_prog(input int hlt_at, output int pc_cnt, output bit got_done);
    pc_cnt = 0; got_done = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      cpu_hlt = (k == hlt_at);
      if (cpu_pc_en === 1'b1) pc_cnt++;
      tick();
      cpu_hlt = 1'b0;
      if (done === 1'b1) begin got_done = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    CLR = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hABCD;
    tick(); tick();
    total++;
    if ({cpu_clr_n, cpu_pc_en, cpu_instr2mem_en, cpu_imem_en, bus.in_ready, busy, done, timeout} !== 8'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000000",
        {cpu_clr_n, cpu_pc_en, cpu_instr2mem_en, cpu_imem_en, bus.in_ready, busy, done, timeout});
    end
    total++;
    if (cpu_instr_addr !== 16'd0 || cycles !== 16'd0) begin
      bad++; $display("FAIL reset_regs: addr=%0h cycles=%0d want 0 0", cpu_instr_addr, cycles);
    end
    CLR = 1'b0; bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_hlt;
    int w0, pc; bit ok;
    logic [15:0] word;
    cycle_limit = 16'd0; w0 = wr_cnt;
    pulse_load(9'd4);
    for (int i = 0; i < 4; i++) begin
      word = 16'h1111 * 16'(i + 1);
      bus.in_valid = 1'b1; bus.in_data = word; #1;
      total++;
      if ({bus.in_ready, cpu_imem_en, cpu_instr2mem_en, cpu_clr_n} !== 4'b1110 ||
          cpu_instr_addr !== 16'(i) || cpu_instr_in !== word) begin
        bad++; $display("FAIL load_word%0d: rdy/we/i2m/clrn=%b addr=%0h data=%h want 1110 %0h %h",
          i, {bus.in_ready, cpu_imem_en, cpu_instr2mem_en, cpu_clr_n}, cpu_instr_addr, cpu_instr_in, i, word);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if ({bus.in_ready, cpu_clr_n, cpu_pc_en, busy} !== 4'b0001) begin
      bad++; $display("FAIL crst1: rdy/clrn/pcen/busy=%b want 0001", {bus.in_ready, cpu_clr_n, cpu_pc_en, busy});
    end
    tick();
    total++;
    if ({cpu_clr_n, cpu_pc_en} !== 2'b00) begin
      bad++; $display("FAIL crst2: clrn/pcen=%b want 00", {cpu_clr_n, cpu_pc_en});
    end
    tick();
    total++;
    if ({cpu_clr_n, cpu_pc_en, cpu_instr2mem_en} !== 3'b110 || wr_cnt - w0 != 4) begin
      bad++; $display("FAIL run_entry: clrn/pcen/i2m=%b writes=%0d want 110 4",
        {cpu_clr_n, cpu_pc_en, cpu_instr2mem_en}, wr_cnt - w0);
    end
    run_prog(4, pc, ok);
    total++;
    if (!ok || {done, timeout, cpu_pc_en, cpu_clr_n, busy} !== 5'b10010 || cycles !== 16'd4 || pc != 4) begin
      bad++; $display("FAIL hlt_run: ok=%0b done/to/pcen/clrn/busy=%b cycles=%0d pc=%0d want 1 10010 4 4",
        ok, {done, timeout, cpu_pc_en, cpu_clr_n, busy}, cycles, pc);
    end
  endtask

  task automatic test_limit;
    int w0, pc; bit ok;
    cycle_limit = 16'd10; w0 = wr_cnt;
    pulse_run();
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || cycles !== 16'd0) begin
      bad++; $display("FAIL rerun_clear: done=%b busy=%b cycles=%0d want 0 1 0", done, busy, cycles);
    end
    wait_run(ok);
    run_prog(0, pc, ok);
    total++;
    if (!ok || timeout !== 1'b1 || cycles !== 16'd10 || pc != 10 || wr_cnt != w0) begin
      bad++; $display("FAIL limit_run: done=%0b timeout=%b cycles=%0d pc=%0d writes=%0d want 1 1 10 10 0",
        ok, timeout, cycles, pc, wr_cnt - w0);
    end
  endtask

  task automatic test_coincident;
    int pc; bit ok;
    cycle_limit = 16'd4;
    pulse_run();
    wait_run(ok);
    run_prog(4, pc, ok);
    total++;
    if (!ok || timeout !== 1'b0 || cycles !== 16'd4 || pc != 4) begin
      bad++; $display("FAIL hlt_vs_limit: done=%0b timeout=%b cycles=%0d pc=%0d want 1 0 4 4", ok, timeout, cycles, pc);
    end
  endtask

  task automatic test_priority;
    int w0, pc; bit ok;
    cycle_limit = 16'd0;
    load_len = 9'd0; load_start = 1'b1; tick(); load_start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL len0_ignored: done=%b busy=%b rdy=%b want 1 0 0", done, busy, bus.in_ready);
    end
    load_len = 9'd1; load_start = 1'b1; run_start = 1'b1;
    tick();
    load_start = 1'b0; run_start = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || cpu_instr2mem_en !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL load_wins: rdy=%b i2m=%b done=%b want 1 1 0", bus.in_ready, cpu_instr2mem_en, done);
    end
    bus.in_valid = 1'b1; bus.in_data = 16'hF000;
    tick();
    bus.in_valid = 1'b0;
    wait_run(ok);
    run_prog(1, pc, ok);
    total++;
    if (!ok || timeout !== 1'b0 || cycles !== 16'd1) begin
      bad++; $display("FAIL hlt_first_cycle: done=%0b timeout=%b cycles=%0d want 1 0 1", ok, timeout, cycles);
    end
    w0 = wr_cnt;
    pulse_run();
    wait_run(ok);
    run_prog(2, pc, ok);
    total++;
    if (!ok || cycles !== 16'd2 || wr_cnt != w0) begin
      bad++; $display("FAIL rerun_no_load: done=%0b cycles=%0d writes=%0d want 1 2 0", ok, cycles, wr_cnt - w0);
    end
  endtask

  task automatic test_backpressure;
    int w0, n, err, last; bit fin, ok;
    cycle_limit = 16'd3; w0 = wr_cnt; n = 0; err = 0; last = -1; fin = 1'b0;
    pulse_load(9'd300);
    for (int c = 0; c < 1200; c++) begin
      if (bus.in_ready !== 1'b1) begin fin = 1'b1; break; end
      bus.in_valid = (c % 2 == 0); bus.in_data = 16'(c); #1;
      if (cpu_imem_en === 1'b1) begin
        if (cpu_instr_addr !== 16'(n % 256)) err++;
        last = int'(cpu_instr_addr); n++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    total++;
    if (!fin || n != 256 || last != 255 || err != 0 || wr_cnt - w0 != 256) begin
      bad++; $display("FAIL clamp_256: ended=%0b words=%0d last_addr=%0d addr_errs=%0d writes=%0d want 1 256 255 0 256",
        fin, n, last, err, wr_cnt - w0);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok || timeout !== 1'b1 || cycles !== 16'd3) begin
      bad++; $display("FAIL clamp_run: done=%0b timeout=%b cycles=%0d want 1 1 3", ok, timeout, cycles);
    end
  endtask

  task automatic test_clr_abort;
    int w0;
    w0 = wr_cnt;
    pulse_load(9'd10);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h0500 + 16'(i); tick();
    end
    CLR = 1'b1; #1;
    total++;
    if (cpu_imem_en !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL clr_gate: we=%b rdy=%b want 0 0", cpu_imem_en, bus.in_ready);
    end
    tick();
    total++;
    if ({cpu_clr_n, cpu_pc_en, cpu_instr2mem_en, cpu_imem_en, bus.in_ready, busy, done, timeout} !== 8'b0 ||
        cpu_instr_addr !== 16'd0 || cycles !== 16'd0) begin
      bad++; $display("FAIL clr_outputs: flags=%b addr=%0h cycles=%0d want 00000000 0 0",
        {cpu_clr_n, cpu_pc_en, cpu_instr2mem_en, cpu_imem_en, bus.in_ready, busy, done, timeout}, cpu_instr_addr, cycles);
    end
    CLR = 1'b0; bus.in_valid = 1'b0;
    tick();
    total++;
    if (wr_cnt - w0 != 5 || busy !== 1'b0 || cpu_clr_n !== 1'b0) begin
      bad++; $display("FAIL clr_writes: writes=%0d busy=%b clrn=%b want 5 0 0", wr_cnt - w0, busy, cpu_clr_n);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0;
    test_reset();
    test_load_hlt();
    test_limit();
    test_coincident();
    test_priority();
    test_backpressure();
    test_clr_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
